program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 24 ++
 rtl/program_loader.sv | 143 ++++++++++++++
 tb/tb_program_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Instruction-memory debug write port driven by the program loader.
interface program_loader_if #(
  parameter int unsigned NB_DATA    = 32,
  parameter int unsigned NB_ADDRESS = 32
);
  logic                  debug;
  logic                  debug_w_en;
  logic [NB_ADDRESS-1:0] debug_w_addr;
  logic [NB_DATA-1:0]    debug_w_data;

  modport master (
    output debug,
    output debug_w_en,
    output debug_w_addr,
    output debug_w_data
  );

  modport slave (
    input debug,
    input debug_w_en,
    input debug_w_addr,
    input debug_w_data
  );
endinterface

// File: rtl/program_loader.sv
// Byte-stream command decoder: loads instruction memory ('L'), runs ('R')
// or single-steps ('S') the pipeline.
module program_loader #(
  parameter int unsigned         NB_DATA       = 32,
  parameter int unsigned         NB_ADDRESS    = 32,
  parameter int unsigned         N_MEM_ADDRESS = 128,
  parameter logic [NB_DATA-1:0]  HALT_CODE     = NB_DATA'(32'hFFFF_FFFF)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_cpu_halted,
  program_loader_if.master      dbg,
  output logic                  o_cpu_clk_en,
  output logic                  o_cpu_reset,
  output logic                  o_load_done,
  output logic [NB_ADDRESS-1:0] o_word_count,
  output logic [1:0]            o_state
);

  localparam int unsigned NB_BYTE  = 8;
  localparam int unsigned NB_SHIFT = NB_DATA - NB_BYTE;

  localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_MEM_ADDRESS - 1);
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NB_ADDRESS-1:0] addr_q, addr_d;
  logic [NB_ADDRESS-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [NB_SHIFT-1:0]   shift_q, shift_d;
  logic [NB_DATA-1:0]    w_data_q, w_data_d;
  logic                  w_en_q, w_en_d;
  logic                  load_done_q, load_done_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic [NB_DATA-1:0]    word_c;

  // Incoming byte completes the word MSB-first.
  assign word_c = {shift_q, i_rx_data};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      w_data_q    <= '0;
      w_en_q      <= 1'b0;
      load_done_q <= 1'b0;
      cpu_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      w_data_q    <= w_data_d;
      w_en_q      <= w_en_d;
      load_done_q <= load_done_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    w_data_d    = w_data_q;
    w_en_d      = 1'b0;
    load_done_d = 1'b0;
    cpu_reset_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d     = LOAD;
              addr_d      = '0;
              byte_cnt_d  = '0;
              word_cnt_d  = '0;
              cpu_reset_d = 1'b1;
            end
            CMD_RUN:  state_d = RUN;
            CMD_STEP: state_d = STEP;
            default:  ;
          endcase
        end
      end
      LOAD: begin
        if (i_rx_valid) begin
          shift_d    = word_c[NB_SHIFT-1:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            w_en_d      = 1'b1;
            w_data_d    = word_c;
            load_done_d = (word_c == HALT_CODE) || (addr_q == LAST_ADDR);
          end
        end
        // Advance the index once the write strobe has been presented.
        if (w_en_q) begin
          addr_d     = addr_q + NB_ADDRESS'(1);
          word_cnt_d = word_cnt_q + NB_ADDRESS'(1);
          if (load_done_q) state_d = IDLE;
        end
      end
      RUN: begin
        if (i_cpu_halted) state_d = IDLE;
      end
      STEP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clock enable follows i_cpu_halted combinationally so it drops in the halt cycle.
  assign o_cpu_clk_en = ((state_q == RUN) && !i_cpu_halted) || (state_q == STEP);

  assign dbg.debug        = (state_q == LOAD);
  assign dbg.debug_w_en   = w_en_q;
  assign dbg.debug_w_addr = addr_q;
  assign dbg.debug_w_data = w_data_q;

  assign o_cpu_reset  = cpu_reset_q;
  assign o_load_done  = load_done_q;
  assign o_word_count = word_cnt_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, run, step, reset and command filtering.
module tb_program_loader;

  localparam int unsigned NB_DATA    = 32;
  localparam int unsigned NB_ADDRESS = 32;
  localparam int unsigned N_MEM      = 128;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  cpu_halted;
  logic                  cpu_clk_en;
  logic                  cpu_reset;
  logic                  load_done;
  logic [NB_ADDRESS-1:0] word_count;
  logic [1:0]            state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  program_loader_if #(.NB_DATA(NB_DATA), .NB_ADDRESS(NB_ADDRESS)) bus ();

  program_loader #(
    .NB_DATA      (NB_DATA),
    .NB_ADDRESS   (NB_ADDRESS),
    .N_MEM_ADDRESS(N_MEM),
    .HALT_CODE    (32'hFFFF_FFFF)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .i_cpu_halted(cpu_halted),
    .dbg         (bus),
    .o_cpu_clk_en(cpu_clk_en),
    .o_cpu_reset (cpu_reset),
    .o_load_done (load_done),
    .o_word_count(word_count),
    .o_state     (state)
  );

  // Write log and pulse counters sampled mid-cycle.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic        wr_done_q[$];
  logic        wr_dbg_q[$];
  int clk_en_cnt  = 0;
  int cpu_rst_cnt = 0;
  int done_cnt    = 0;
  int busy_cnt    = 0;

  always @(negedge clk) begin
    if (bus.debug_w_en === 1'b1) begin
      wr_addr_q.push_back(bus.debug_w_addr);
      wr_data_q.push_back(bus.debug_w_data);
      wr_done_q.push_back(load_done);
      wr_dbg_q.push_back(bus.debug);
    end
    if (cpu_clk_en === 1'b1) clk_en_cnt  <= clk_en_cnt + 1;
    if (cpu_reset === 1'b1)  cpu_rst_cnt <= cpu_rst_cnt + 1;
    if (load_done === 1'b1)  done_cnt    <= done_cnt + 1;
    if (state !== 2'd0)      busy_cnt    <= busy_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int base_wr, base_rst, base_done, base_en, base_busy, bad;
    logic [31:0] exp_data;

    reset      = 1'b1;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    cpu_halted = 1'b0;
    wait_cycles(3);

    check_eq("rst_state",     64'(state),             64'd0);
    check_eq("rst_debug",     64'(bus.debug),         64'd0);
    check_eq("rst_w_en",      64'(bus.debug_w_en),    64'd0);
    check_eq("rst_w_addr",    64'(bus.debug_w_addr),  64'd0);
    check_eq("rst_w_data",    64'(bus.debug_w_data),  64'd0);
    check_eq("rst_clk_en",    64'(cpu_clk_en),        64'd0);
    check_eq("rst_cpu_reset", 64'(cpu_reset),         64'd0);
    check_eq("rst_load_done", 64'(load_done),         64'd0);
    check_eq("rst_word_cnt",  64'(word_count),        64'd0);
    reset = 1'b0;
    wait_cycles(2);

    // Two-word program terminated by the halt word.
    base_wr   = wr_addr_q.size();
    base_rst  = cpu_rst_cnt;
    base_done = done_cnt;
    send_byte(8'h4C);
    check_eq("L_state",     64'(state),     64'd1);
    check_eq("L_debug",     64'(bus.debug), 64'd1);
    check_eq("L_cpu_reset", 64'(cpu_reset), 64'd1);
    send_word(32'h0000_0013);
    send_word(32'hFFFF_FFFF);
    wait_cycles(3);
    check_eq("A_nwr", 64'(wr_addr_q.size() - base_wr), 64'd2);
    if (wr_addr_q.size() - base_wr == 2) begin
      check_eq("A_addr0", 64'(wr_addr_q[base_wr]),     64'd0);
      check_eq("A_data0", 64'(wr_data_q[base_wr]),     64'h13);
      check_eq("A_done0", 64'(wr_done_q[base_wr]),     64'd0);
      check_eq("A_addr1", 64'(wr_addr_q[base_wr + 1]), 64'd1);
      check_eq("A_data1", 64'(wr_data_q[base_wr + 1]), 64'hFFFF_FFFF);
      check_eq("A_done1", 64'(wr_done_q[base_wr + 1]), 64'd1);
      check_eq("A_dbg1",  64'(wr_dbg_q[base_wr + 1]),  64'd1);
    end
    check_eq("A_word_cnt",   64'(word_count),             64'd2);
    check_eq("A_state",      64'(state),                  64'd0);
    check_eq("A_debug_off",  64'(bus.debug),              64'd0);
    check_eq("A_rst_pulses", 64'(cpu_rst_cnt - base_rst), 64'd1);
    check_eq("A_done_pulse", 64'(done_cnt - base_done),   64'd1);

    // Fill the whole memory with non-halt words.
    base_wr   = wr_addr_q.size();
    base_done = done_cnt;
    send_byte(8'h4C);
    for (int i = 0; i < int'(N_MEM); i++) send_word(32'h0000_1000 + 32'(i));
    wait_cycles(3);
    check_eq("B_nwr", 64'(wr_addr_q.size() - base_wr), 64'd128);
    bad = 0;
    if (wr_addr_q.size() - base_wr == 128) begin
      for (int i = 0; i < int'(N_MEM); i++) begin
        exp_data = 32'h0000_1000 + 32'(i);
        if (wr_addr_q[base_wr + i] !== 32'(i))     bad++;
        if (wr_data_q[base_wr + i] !== exp_data)   bad++;
        if (wr_done_q[base_wr + i] !== (i == 127)) bad++;
      end
    end else begin
      bad = 1;
    end
    check_eq("B_seq_errors", 64'(bad),                   64'd0);
    check_eq("B_done_pulse", 64'(done_cnt - base_done),  64'd1);
    check_eq("B_word_cnt",   64'(word_count),            64'd128);
    check_eq("B_state",      64'(state),                 64'd0);

    // Next byte after a full load is a command: single step.
    base_en = clk_en_cnt;
    send_byte(8'h53);
    check_eq("S_state",  64'(state),      64'd3);
    check_eq("S_clk_en", 64'(cpu_clk_en), 64'd1);
    wait_cycles(3);
    check_eq("S_idle",    64'(state),                64'd0);
    check_eq("S_en_cycles", 64'(clk_en_cnt - base_en), 64'd1);

    // Run for ten cycles, then halt.
    base_en = clk_en_cnt;
    send_byte(8'h52);
    check_eq("R_state",  64'(state),      64'd2);
    check_eq("R_clk_en", 64'(cpu_clk_en), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    cpu_halted = 1'b1;
    @(negedge clk);
    check_eq("R_halt_clk_en", 64'(cpu_clk_en), 64'd0);
    check_eq("R_halt_state",  64'(state),      64'd2);
    @(posedge clk);
    #1;
    cpu_halted = 1'b0;
    check_eq("R_idle",      64'(state),                64'd0);
    check_eq("R_en_cycles", 64'(clk_en_cnt - base_en), 64'd10);

    // Partial word discarded by reset mid-load.
    base_wr = wr_addr_q.size();
    send_byte(8'h4C);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_reset();
    check_eq("X_state", 64'(state),     64'd0);
    check_eq("X_debug", 64'(bus.debug), 64'd0);
    send_byte(8'h4C);
    send_word(32'h1122_3344);
    wait_cycles(3);
    check_eq("X_nwr", 64'(wr_addr_q.size() - base_wr), 64'd1);
    if (wr_addr_q.size() - base_wr == 1) begin
      check_eq("X_addr", 64'(wr_addr_q[base_wr]), 64'd0);
      check_eq("X_data", 64'(wr_data_q[base_wr]), 64'h1122_3344);
    end
    check_eq("X_word_cnt", 64'(word_count), 64'd1);
    check_eq("X_in_load",  64'(state),      64'd1);
    pulse_reset();

    // Reset mid-run wins over the running state.
    send_byte(8'h52);
    pulse_reset();
    check_eq("Y_state",  64'(state),      64'd0);
    check_eq("Y_clk_en", 64'(cpu_clk_en), 64'd0);

    // Non-command byte and stray data in IDLE are ignored.
    wait_cycles(2);
    base_wr   = wr_addr_q.size();
    base_busy = busy_cnt;
    send_byte(8'h41);
    send_word(32'h0000_0013);
    wait_cycles(3);
    check_eq("Z_busy", 64'(busy_cnt - base_busy),         64'd0);
    check_eq("Z_nwr",  64'(wr_addr_q.size() - base_wr),   64'd0);
    check_eq("Z_state", 64'(state),                       64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
